// File: rtl/cla_multiword_seq_ctrl.sv
// Multi-word adder sequencer: drives one external 4-bit CLA slice a nibble per
// cycle, LSB first, chaining the carry through a register.
module cla_multiword_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic [3:0]       cla_a,
  output logic [3:0]       cla_b,
  output logic             cla_cin,
  input  logic [3:0]       cla_sum,
  input  logic             cla_cout
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IW      = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;

  // Slice inputs depend only on registers, so the combinational slice output
  // can be consumed in the same cycle without forming a loop.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    cla_a   = 4'd0;
    cla_b   = 4'd0;
    cla_cin = 1'b0;
    if (state == S_RUN) begin
      cla_a   = a_reg[4*idx +: 4];
      cla_b   = b_reg[4*idx +: 4];
      cla_cin = carry;
    end
  end

  // Accumulator image including the nibble being resolved this cycle.
  always_comb begin
    acc_next              = acc;
    acc_next[4*idx +: 4]  = cla_sum;
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge; all state here is plain flops, so clearing it all is cheap.
    if (!rst) begin
      state    <= S_IDLE;
      idx      <= '0;
      carry    <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      acc      <= '0;
      sum      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            carry <= c_in;
            idx   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          acc   <= acc_next;
          carry <= cla_cout;
          if (idx == LAST) begin
            sum      <= acc_next;
            c_out    <= cla_cout;
            overflow <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                        (cla_sum[3] != a_reg[WIDTH-1]);
            done     <= 1'b1;
            state    <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
